// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// requester identities and the reset value of the write port.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic WB_RST_REGWRITE = 1'b0;

  // Round-robin successor: after a grant, priority moves to the other requester.
  function automatic req_id_e other_req(input req_id_e r);
    return (r == REQ_ALU) ? REQ_LSU : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 never set.
// A set and a clear of the same register on one edge leaves the bit set.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] rd1_idx_i,
  input  logic [ADDR_W-1:0] rd2_idx_i,
  output logic              hazard1_o,
  output logic              hazard2_o
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] bits_q;
  logic [NREG-1:0] bits_d;

  // Clear is applied before set so a newer producer keeps its bit.
  always_comb begin
    bits_d = bits_q;
    if (clr_en_i) begin
      bits_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i && (set_idx_i != '0)) begin
      bits_d[set_idx_i] = 1'b1;
    end
    bits_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign hazard1_o = bits_q[rd1_idx_i];
  assign hazard2_o = bits_q[rd2_idx_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// the LSU, with a registered write stage and a pending-write hazard scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0_Valid,
  input  logic [ADDR_W-1:0] Req0_Reg,
  input  logic [DATA_W-1:0] Req0_Data,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic [ADDR_W-1:0] Req1_Reg,
  input  logic [DATA_W-1:0] Req1_Data,
  output logic              Req1_Ready,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  req_id_e           ptr_q, ptr_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt0, gnt1;

  always_comb begin
    gnt0 = Req0_Valid && (!Req1_Valid || (ptr_q == REQ_ALU));
    gnt1 = Req1_Valid && (!Req0_Valid || (ptr_q == REQ_LSU));
  end

  // A grant to register 0 still occupies the slot and moves the pointer,
  // but never raises the write enable.
  always_comb begin
    ptr_d      = ptr_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (gnt0) begin
      ptr_d      = other_req(REQ_ALU);
      regwrite_d = (Req0_Reg != '0);
      wreg_d     = Req0_Reg;
      wdata_d    = Req0_Data;
    end else if (gnt1) begin
      ptr_d      = other_req(REQ_LSU);
      regwrite_d = (Req1_Reg != '0);
      wreg_d     = Req1_Reg;
      wdata_d    = Req1_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ptr_q      <= REQ_ALU;
      regwrite_q <= WB_RST_REGWRITE;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .set_en_i  (Issue_Valid),
    .set_idx_i (Issue_Reg),
    .clr_en_i  (regwrite_q),
    .clr_idx_i (wreg_q),
    .rd1_idx_i (ReadReg1),
    .rd2_idx_i (ReadReg2),
    .hazard1_o (Hazard1),
    .hazard2_o (Hazard2)
  );

  assign Req0_Ready = gnt0;
  assign Req1_Ready = gnt1;
  assign RegWrite   = regwrite_q;
  assign WriteReg   = wreg_q;
  assign WriteData  = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change just after each negedge,
// outputs are checked 1ns later, well clear of the rising edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Req0_Valid, Req1_Valid, Issue_Valid;
  logic [AW-1:0] Req0_Reg, Req1_Reg, Issue_Reg, ReadReg1, ReadReg2;
  logic [DW-1:0] Req0_Data, Req1_Data;
  logic          Req0_Ready, Req1_Ready, Hazard1, Hazard2, RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Req0_Valid  (Req0_Valid),
    .Req0_Reg    (Req0_Reg),
    .Req0_Data   (Req0_Data),
    .Req0_Ready  (Req0_Ready),
    .Req1_Valid  (Req1_Valid),
    .Req1_Reg    (Req1_Reg),
    .Req1_Data   (Req1_Data),
    .Req1_Ready  (Req1_Ready),
    .Issue_Valid (Issue_Valid),
    .Issue_Reg   (Issue_Reg),
    .ReadReg1    (ReadReg1),
    .ReadReg2    (ReadReg2),
    .Hazard1     (Hazard1),
    .Hazard2     (Hazard2),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge; caller then sets inputs and checks after #1.
  task automatic step();
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    Req0_Valid = 1'b0; Req0_Reg = '0; Req0_Data = '0;
    Req1_Valid = 1'b0; Req1_Reg = '0; Req1_Data = '0;
    Issue_Valid = 1'b0; Issue_Reg = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst_n = 1'b0;
    step(); step();
    Rst_n = 1'b1;
  endtask

  logic [AW-1:0] exp_reg [4];

  initial begin
    ReadReg1 = '0; ReadReg2 = '0;
    step();
    do_reset();
    #1;
    chk("rst_regwrite",  {31'b0, RegWrite}, 32'd0);
    chk("rst_writereg",  {27'b0, WriteReg}, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_ready0",    {31'b0, Req0_Ready}, 32'd0);

    // 1: single ALU write, latency 1
    step();
    Req0_Valid = 1'b1; Req0_Reg = 5'd5; Req0_Data = 32'h1234;
    #1 chk("t1_ready0", {31'b0, Req0_Ready}, 32'd1);
    chk("t1_ready1", {31'b0, Req1_Ready}, 32'd0);
    step();
    Req0_Valid = 1'b0;
    #1 chk("t1_regwrite", {31'b0, RegWrite}, 32'd1);
    chk("t1_writereg",  {27'b0, WriteReg}, 32'd5);
    chk("t1_writedata", WriteData, 32'h1234);
    chk("t1_ready0_lo", {31'b0, Req0_Ready}, 32'd0);
    step();
    #1 chk("t1_regwrite_lo", {31'b0, RegWrite}, 32'd0);
    chk("t1_writereg_hold", {27'b0, WriteReg}, 32'd5);

    // 2: both valid every cycle, alternating from requester 0 after reset
    do_reset();
    exp_reg[0] = 5'd3; exp_reg[1] = 5'd4; exp_reg[2] = 5'd3; exp_reg[3] = 5'd4;
    Req0_Valid = 1'b1; Req0_Reg = 5'd3; Req0_Data = 32'hA0;
    Req1_Valid = 1'b1; Req1_Reg = 5'd4; Req1_Data = 32'hB1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        chk($sformatf("t2_ready0_%0d", i), {31'b0, Req0_Ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t2_ready1_%0d", i), {31'b0, Req1_Ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (i > 0) begin
        chk($sformatf("t2_regwrite_%0d", i), {31'b0, RegWrite}, 32'd1);
        chk($sformatf("t2_writereg_%0d", i), {27'b0, WriteReg}, {27'b0, exp_reg[i-1]});
        chk($sformatf("t2_writedata_%0d", i), WriteData, (i % 2 == 1) ? 32'hA0 : 32'hB1);
      end
      step();
    end
    #1 chk("t2_regwrite_end", {31'b0, RegWrite}, 32'd0);

    // 3: issue r7, hazard through the LSU write
    Issue_Valid = 1'b1; Issue_Reg = 5'd7; ReadReg1 = 5'd7;
    #1 chk("t3_haz_before", {31'b0, Hazard1}, 32'd0);
    step();
    Issue_Valid = 1'b0;
    #1 chk("t3_haz_set", {31'b0, Hazard1}, 32'd1);
    step();
    Req1_Valid = 1'b1; Req1_Reg = 5'd7; Req1_Data = 32'h77;
    #1 chk("t3_ready1", {31'b0, Req1_Ready}, 32'd1);
    chk("t3_haz_grant", {31'b0, Hazard1}, 32'd1);
    step();
    Req1_Valid = 1'b0;
    #1 chk("t3_regwrite", {31'b0, RegWrite}, 32'd1);
    chk("t3_writereg", {27'b0, WriteReg}, 32'd7);
    chk("t3_haz_wrcyc", {31'b0, Hazard1}, 32'd1);
    step();
    #1 chk("t3_haz_clear", {31'b0, Hazard1}, 32'd0);

    // 4: clear and re-set of r9 on the same edge keeps the bit
    step();
    Issue_Valid = 1'b1; Issue_Reg = 5'd9; ReadReg2 = 5'd9;
    step();
    Issue_Valid = 1'b0;
    Req0_Valid = 1'b1; Req0_Reg = 5'd9; Req0_Data = 32'h99;
    #1 chk("t4_ready0", {31'b0, Req0_Ready}, 32'd1);
    chk("t4_haz_pre", {31'b0, Hazard2}, 32'd1);
    step();
    Req0_Valid = 1'b0;
    Issue_Valid = 1'b1; Issue_Reg = 5'd9;
    #1 chk("t4_regwrite", {31'b0, RegWrite}, 32'd1);
    step();
    Issue_Valid = 1'b0;
    #1 chk("t4_haz_kept", {31'b0, Hazard2}, 32'd1);
    chk("t4_regwrite_lo", {31'b0, RegWrite}, 32'd0);

    // 5: register 0 handshakes but never writes or flags a hazard
    step();
    Req0_Valid = 1'b1; Req0_Reg = 5'd0; Req0_Data = 32'hFFFF;
    Issue_Valid = 1'b1; Issue_Reg = 5'd0; ReadReg1 = 5'd0;
    #1 chk("t5_ready0", {31'b0, Req0_Ready}, 32'd1);
    step();
    Req0_Valid = 1'b0; Issue_Valid = 1'b0;
    #1 chk("t5_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("t5_haz_r0", {31'b0, Hazard1}, 32'd0);

    // 6: reset mid-stream drops pending bits and the in-flight grant
    step();
    Issue_Valid = 1'b1; Issue_Reg = 5'd2;
    step();
    Issue_Reg = 5'd6;
    step();
    Issue_Valid = 1'b0; ReadReg1 = 5'd2; ReadReg2 = 5'd6;
    Req1_Valid = 1'b1; Req1_Reg = 5'd11; Req1_Data = 32'hBB;
    #1 chk("t6_haz2_pre", {31'b0, Hazard1}, 32'd1);
    chk("t6_haz6_pre", {31'b0, Hazard2}, 32'd1);
    chk("t6_ready1", {31'b0, Req1_Ready}, 32'd1);
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1; Req1_Valid = 1'b0;
    #1 chk("t6_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("t6_writereg", {27'b0, WriteReg}, 32'd0);
    chk("t6_haz2", {31'b0, Hazard1}, 32'd0);
    chk("t6_haz6", {31'b0, Hazard2}, 32'd0);
    step();
    Req0_Valid = 1'b1; Req0_Reg = 5'd1; Req0_Data = 32'h1;
    Req1_Valid = 1'b1; Req1_Reg = 5'd2; Req1_Data = 32'h2;
    #1 chk("t6_ptr_ready0", {31'b0, Req0_Ready}, 32'd1);
    chk("t6_ptr_ready1", {31'b0, Req1_Ready}, 32'd0);
    step();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load/store unit.
- Arbitrates round-robin and drives RegWrite/WriteReg/WriteData from a registered output stage.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on ReadReg1/ReadReg2.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
Clk  input  1  clock; all state updates on posedge
Rst_n  input  1  synchronous active-low reset
Req0_Valid  input  1  ALU writeback request
Req0_Reg  input  ADDR_W  ALU destination register
Req0_Data  input  DATA_W  ALU result
Req0_Ready  output  1  ALU request accepted this cycle
Req1_Valid  input  1  LSU writeback request
Req1_Reg  input  ADDR_W  LSU destination register
Req1_Data  input  DATA_W  LSU load data
Req1_Ready  output  1  LSU request accepted this cycle
Issue_Valid  input  1  decode issued an instruction with a destination
Issue_Reg  input  ADDR_W  destination of the issued instruction
ReadReg1  input  ADDR_W  source register 1 being decoded
ReadReg2  input  ADDR_W  source register 2 being decoded
Hazard1  output  1  ReadReg1 has a pending write
Hazard2  output  1  ReadReg2 has a pending write
RegWrite  output  1  register-file write enable
WriteReg  output  ADDR_W  register-file write index
WriteData  output  DATA_W  register-file write data

Behaviour:
- Reset (Rst_n=0 at posedge):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - Scoreboard cleared to all zeros.
  - Priority pointer set to requester 0.
  - Reset overrides any in-flight grant or issue; an accepted request that is not yet written is dropped.
- Arbitration is combinational within the cycle:
  - Only one valid requester: that requester is granted.
  - Both valid: grant the requester the pointer names. The pointer then flips to the other requester. It changes only on a cycle with a grant.
  - ReqN_Ready equals grantN. The handshake completes when ReqN_Valid and ReqN_Ready are both 1. A requester holds Valid/Reg/Data stable until Ready.
  - Ready never asserts without Valid. At most one Ready per cycle.
- Output stage, one register, latency 1:
  - Grant in cycle t loads WriteReg/WriteData at the posedge ending t. RegWrite=1 during t+1. The register file writes at the posedge ending t+1.
  - No grant: RegWrite=0 next cycle. WriteReg/WriteData hold their previous values.
- Register 0:
  - A request with Reg=0 is still granted and handshaken.
  - RegWrite stays 0 for it. It consumes the slot and flips the pointer.
- Scoreboard, 2**ADDR_W bits, bit 0 hardwired to 0:
  - Set: Issue_Valid=1 with Issue_Reg!=0 sets bit[Issue_Reg] at the posedge.
  - Clear: RegWrite=1 clears bit[WriteReg] at the posedge, the same edge the register file writes.
  - Set and clear of the same register on the same edge: set wins, because a newer producer is in flight.
  - Hazard1 = bit[ReadReg1], Hazard2 = bit[ReadReg2]. Both are combinational from the current scoreboard.
  - During the RegWrite cycle the bit is still 1. Hazard drops in the cycle the register file holds the new value.
- Single outstanding producer per register: one bit per register, no count. Decode must stall on a hazard before reissuing the same destination.

Decomposition:
- Shared package holds: DATA_W/ADDR_W defaults, the requester index constants (ALU=0, LSU=1), and the reset value of the write-port outputs.
- Sub-module wb_scoreboard holds: the bit vector, set/clear with set-priority, and the two hazard read ports.
- The top level holds the round-robin arbiter and the output register.

Test Plan:
1. Reset, then Req0_Valid=1 Reg=5 Data=0x1234 -> Req0_Ready=1 same cycle. Next cycle RegWrite=1, WriteReg=5, WriteData=0x1234. Following cycle RegWrite=0.
2. Both valid every cycle (Req0 Reg=3, Req1 Reg=4) -> grants alternate 0,1,0,1. WriteReg sequence 3,4,3,4, one write per cycle.
3. Issue_Valid Reg=7 -> Hazard1=1 when ReadReg1=7 from the next cycle. Req1 Reg=7 granted -> hazard still 1 during the RegWrite cycle, 0 the cycle after.
4. RegWrite on reg 9 and Issue_Valid Reg=9 on the same edge -> bit 9 remains 1 and Hazard2=1 for ReadReg2=9.
5. Req0 Reg=0 Data=0xFFFF -> Req0_Ready=1 and RegWrite stays 0. Issue_Reg=0 -> Hazard on reg 0 never asserts.
6. Rst_n=0 mid-stream with the scoreboard holding bits 2 and 6 and a grant pending -> next cycle RegWrite=0, all hazards 0, pointer favors requester 0.
